// File: rtl/kcpsm6_irq_ctrl.sv
// kcpsm6_irq_ctrl
//   Multi-channel interrupt controller for a single kcpsm6 core. It collects
//   NUM_IRQ request lines and gives each channel edge or level sensitivity and a
//   mask bit. Requests are arbitrated by fixed or round-robin priority, and the
//   winner is presented on the kcpsm6 interrupt/interrupt_ack handshake.
//   Firmware accesses four registers through the kcpsm6 I/O port bus:
//     +0 PENDING (R/W1C)  +1 MASK (RW)  +2 VECTOR (R, write = EOI)  +3 CTRL (RW)
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   irq_in         raw requests (asynchronous to clk)
//   port_id, out_port, write_strobe, read_strobe   kcpsm6 I/O bus
//   rd_data, rd_hit                                registered read return
//   cpu_interrupt, cpu_irq_ack                     kcpsm6 interrupt handshake
module kcpsm6_irq_ctrl #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [7:0]  BASE_PORT = 8'hF0,
    parameter logic [7:0]  EDGE_MASK = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    output logic               cpu_interrupt,
    input  logic               cpu_irq_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

    localparam logic [NUM_IRQ-1:0] EDGE_SEL = EDGE_MASK[NUM_IRQ-1:0];

    state_t             state;
    logic [NUM_IRQ-1:0] sync1, sync2, sync3;
    logic [NUM_IRQ-1:0] pending, mask;
    logic [NUM_IRQ-1:0] set_bits, w1c_bits, ack_clear, active;
    logic [1:0]         ctrl;
    logic               in_service;
    logic [2:0]         vec_id, rr_ptr, winner;
    logic               found;
    int                 idx;
    logic               addr_hit;
    logic [1:0]         addr_sel;
    logic               wr_pending, wr_mask, wr_vector, wr_ctrl;
    logic               req, take_ack;
    logic [7:0]         pend8, mask8, rd_mux;

    // Reads are unconditionally registered from port_id, so the strobe carries
    // no information for this block.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    assign addr_hit   = (port_id[7:2] == BASE_PORT[7:2]);
    assign addr_sel   = port_id[1:0];
    assign wr_pending = write_strobe & addr_hit & (addr_sel == 2'd0);
    assign wr_mask    = write_strobe & addr_hit & (addr_sel == 2'd1);
    assign wr_vector  = write_strobe & addr_hit & (addr_sel == 2'd2);
    assign wr_ctrl    = write_strobe & addr_hit & (addr_sel == 2'd3);

    // Edge channels fire once on a synchronised rising edge; level channels
    // re-assert pending every cycle the synchronised line is high.
    assign set_bits = (sync2 & ~sync3 & EDGE_SEL) | (sync2 & ~EDGE_SEL);
    assign w1c_bits = wr_pending ? out_port[NUM_IRQ-1:0] : '0;
    assign active   = pending & mask;
    assign req      = ctrl[0] & (|active);
    assign take_ack = (state == ST_ASSERT) & cpu_irq_ack & req;

    // Winner search. Fixed mode scans upward from channel 0. Round-robin mode
    // scans upward starting one past the last serviced channel and wraps.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx = ctrl[1] ? ((int'(rr_ptr) + 1 + i) % NUM_IRQ) : i;
            if (!found && active[idx]) begin
                winner = 3'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ack_clear = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clear[i] = take_ack && (winner == 3'(i));
        end
    end

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // A new set in the same cycle beats both a W1C and an acknowledge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= '0;
            ctrl    <= '0;
        end else begin
            pending <= (pending & ~w1c_bits & ~ack_clear) | set_bits;
            if (wr_mask) mask <= out_port[NUM_IRQ-1:0];
            if (wr_ctrl) ctrl <= out_port[1:0];
        end
    end

    // Interrupt handshake. The ack uses the winner from the current register
    // state, so a mask write landing on the same edge cannot steal it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cpu_interrupt <= 1'b0;
            in_service    <= 1'b0;
            vec_id        <= '0;
            rr_ptr        <= 3'(NUM_IRQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state         <= ST_ASSERT;
                        cpu_interrupt <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (take_ack) begin
                        vec_id        <= winner;
                        in_service    <= 1'b1;
                        rr_ptr        <= winner;
                        state         <= ST_SERVICE;
                        cpu_interrupt <= 1'b0;
                    end else if (!req) begin
                        state         <= ST_IDLE;
                        cpu_interrupt <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (wr_vector) begin
                        in_service <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    cpu_interrupt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pend8                = '0;
        mask8                = '0;
        pend8[NUM_IRQ-1:0]   = pending;
        mask8[NUM_IRQ-1:0]   = mask;
        case (addr_sel)
            2'd0:    rd_mux = pend8;
            2'd1:    rd_mux = mask8;
            2'd2:    rd_mux = {in_service, 4'b0000, vec_id};
            default: rd_mux = {6'b000000, ctrl};
        endcase
    end

    // kcpsm6 holds port_id for two cycles, so a one-cycle registered read
    // path is still in time for INPUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
            rd_hit  <= 1'b0;
        end else begin
            rd_data <= addr_hit ? rd_mux : 8'h00;
            rd_hit  <= addr_hit;
        end
    end

endmodule

// File: tb/tb_kcpsm6_irq_ctrl.sv
// Testbench for kcpsm6_irq_ctrl. Channels 0-2 are level sensitive, channels
// 3-7 are edge sensitive. The directed scenarios are followed by randomized
// rounds that are checked against a set/pointer model of the arbitration.
module tb_kcpsm6_irq_ctrl;

    localparam logic [7:0] BASE = 8'hF0;
    localparam logic [7:0] EDGE = 8'hF8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic       cpu_interrupt;
    logic       cpu_irq_ack;

    int         assertions = 0;
    int         failures   = 0;
    int         model_rr;

    kcpsm6_irq_ctrl #(.NUM_IRQ(8), .BASE_PORT(BASE), .EDGE_MASK(EDGE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_in        (irq_in),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .rd_data       (rd_data),
        .rd_hit        (rd_hit),
        .cpu_interrupt (cpu_interrupt),
        .cpu_irq_ack   (cpu_irq_ack)
    );

    always #5 clk = ~clk;

    // Reference arbitration: fixed mode picks the lowest active channel;
    // round-robin picks the first active channel after the last one serviced.
    function automatic int model_winner(input logic [7:0] act, input bit rr, input int ptr);
        for (int k = 0; k < 8; k++) begin
            int c;
            c = rr ? ((ptr + 1 + k) % 8) : k;
            if (act[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0; irq_in = 8'h00; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; cpu_irq_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_rr = 7;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        port_id = BASE + {6'b000000, a}; out_port = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic read_reg(input logic [7:0] p, output logic [7:0] d, output logic h);
        @(negedge clk);
        port_id = p; read_strobe = 1'b1;
        @(negedge clk);
        d = rd_data; h = rd_hit; read_strobe = 1'b0;
    endtask

    task automatic wait_int(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_interrupt === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic ack_irq;
        @(negedge clk); cpu_irq_ack = 1'b1;
        @(negedge clk); cpu_irq_ack = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] ch);
        @(negedge clk); irq_in = ch;
        @(negedge clk); irq_in = 8'h00;
    endtask

    task automatic test_reset;
        logic [7:0] d; logic h; bit seen;
        do_reset;
        write_reg(2'd1, 8'h04); write_reg(2'd3, 8'h01);
        pulse_irq(8'h04);
        wait_int(seen);
        assertions++;
        if (!seen) begin failures++; $display("[TB] FAIL reset_setup_int: got %b expected 1", cpu_interrupt); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        assertions++;
        if (cpu_interrupt !== 1'b0) begin failures++; $display("[TB] FAIL reset_async_int: got %b expected 0", cpu_interrupt); end
        @(negedge clk); rst_n = 1'b1; model_rr = 7;
        for (int r = 0; r < 4; r++) begin
            read_reg(BASE + 8'(r), d, h);
            assertions++;
            if (d !== 8'h00 || h !== 1'b1) begin
                failures++; $display("[TB] FAIL reset_reg%0d: got %h hit %b expected 00 hit 1", r, d, h);
            end
        end
    endtask

    task automatic test_registers;
        logic [7:0] d; logic h;
        do_reset;
        write_reg(2'd1, 8'h5A);
        read_reg(BASE + 8'd1, d, h);
        assertions++;
        if (d !== 8'h5A) begin failures++; $display("[TB] FAIL mask_rw: got %h expected 5a", d); end
        write_reg(2'd3, 8'hFE);
        read_reg(BASE + 8'd3, d, h);
        assertions++;
        if (d !== 8'h02) begin failures++; $display("[TB] FAIL ctrl_rw: got %h expected 02", d); end
    endtask

    task automatic test_single;
        logic [7:0] d; logic h;
        do_reset;
        write_reg(2'd1, 8'h04); write_reg(2'd3, 8'h01);
        @(negedge clk); port_id = BASE; irq_in = 8'h04;
        @(negedge clk); irq_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        assertions++;
        if (cpu_interrupt !== 1'b0 || rd_data !== 8'h00) begin
            failures++; $display("[TB] FAIL latency_e2: got int %b pend %h expected 0 00", cpu_interrupt, rd_data);
        end
        @(negedge clk);
        assertions++;
        if (cpu_interrupt !== 1'b1 || rd_data !== 8'h04) begin
            failures++; $display("[TB] FAIL latency_e3: got int %b pend %h expected 1 04", cpu_interrupt, rd_data);
        end
        ack_irq; model_rr = 2;
        read_reg(BASE + 8'd2, d, h);
        assertions++;
        if (d !== 8'h82) begin failures++; $display("[TB] FAIL single_vector: got %h expected 82", d); end
        read_reg(BASE, d, h);
        assertions++;
        if (d !== 8'h00 || cpu_interrupt !== 1'b0) begin
            failures++; $display("[TB] FAIL single_cleared: got pend %h int %b expected 00 0", d, cpu_interrupt);
        end
        write_reg(2'd2, 8'h00);
        read_reg(BASE + 8'd2, d, h);
        assertions++;
        if (d !== 8'h02) begin failures++; $display("[TB] FAIL single_eoi: got %h expected 02", d); end
    endtask

    task automatic test_fixed_priority;
        logic [7:0] d; logic h; bit seen;
        logic [7:0] exp_vec [2];
        exp_vec[0] = 8'h81; exp_vec[1] = 8'h85;
        do_reset;
        write_reg(2'd1, 8'hFF); write_reg(2'd3, 8'h01);
        pulse_irq(8'h22);
        for (int n = 0; n < 2; n++) begin
            wait_int(seen);
            assertions++;
            if (!seen) begin failures++; $display("[TB] FAIL fixed_int%0d: got 0 expected 1", n); end
            ack_irq;
            read_reg(BASE + 8'd2, d, h);
            assertions++;
            if (d !== exp_vec[n]) begin failures++; $display("[TB] FAIL fixed_vec%0d: got %h expected %h", n, d, exp_vec[n]); end
            write_reg(2'd2, 8'h00);
        end
        read_reg(BASE, d, h);
        assertions++;
        if (d !== 8'h00) begin failures++; $display("[TB] FAIL fixed_pend: got %h expected 00", d); end
    endtask

    task automatic test_round_robin;
        logic [7:0] d; logic h; bit seen;
        int exp_ch [4];
        exp_ch[0] = 0; exp_ch[1] = 1; exp_ch[2] = 2; exp_ch[3] = 0;
        do_reset;
        write_reg(2'd1, 8'hFF); write_reg(2'd3, 8'h03);
        @(negedge clk); irq_in = 8'h07;
        for (int n = 0; n < 4; n++) begin
            wait_int(seen);
            assertions++;
            if (!seen) begin failures++; $display("[TB] FAIL rr_int%0d: got 0 expected 1", n); end
            ack_irq;
            read_reg(BASE + 8'd2, d, h);
            assertions++;
            if (d !== (8'h80 | 8'(exp_ch[n]))) begin
                failures++; $display("[TB] FAIL rr_vec%0d: got %h expected %h", n, d, 8'h80 | 8'(exp_ch[n]));
            end
            write_reg(2'd2, 8'h00);
        end
        irq_in = 8'h00;
        repeat (5) @(negedge clk);
        write_reg(2'd0, 8'h07);
        repeat (3) @(negedge clk);
        assertions++;
        if (cpu_interrupt !== 1'b0) begin failures++; $display("[TB] FAIL rr_quiet: got %b expected 0", cpu_interrupt); end
    endtask

    task automatic test_mask_drop;
        logic [7:0] d; logic h; bit seen;
        do_reset;
        write_reg(2'd1, 8'h04); write_reg(2'd3, 8'h01);
        pulse_irq(8'h04);
        wait_int(seen);
        assertions++;
        if (!seen) begin failures++; $display("[TB] FAIL drop_int: got 0 expected 1"); end
        write_reg(2'd1, 8'h00);
        @(negedge clk);
        assertions++;
        if (cpu_interrupt !== 1'b0) begin failures++; $display("[TB] FAIL drop_low: got %b expected 0", cpu_interrupt); end
        read_reg(BASE, d, h);
        assertions++;
        if (d !== 8'h04) begin failures++; $display("[TB] FAIL drop_pend: got %h expected 04", d); end
        read_reg(BASE + 8'd2, d, h);
        assertions++;
        if (d !== 8'h00 || cpu_interrupt !== 1'b0) begin
            failures++; $display("[TB] FAIL drop_idle: got vec %h int %b expected 00 0", d, cpu_interrupt);
        end
    endtask

    task automatic test_w1c_collision;
        logic [7:0] d; logic h;
        do_reset;
        pulse_irq(8'h08);
        repeat (4) @(negedge clk);
        read_reg(BASE, d, h);
        assertions++;
        if (d !== 8'h08) begin failures++; $display("[TB] FAIL w1c_pre: got %h expected 08", d); end
        @(negedge clk); irq_in = 8'h08;
        @(negedge clk); irq_in = 8'h00;
        @(negedge clk); port_id = BASE; out_port = 8'h08; write_strobe = 1'b1;
        @(negedge clk); write_strobe = 1'b0;
        read_reg(BASE, d, h);
        assertions++;
        if (d !== 8'h08) begin failures++; $display("[TB] FAIL w1c_set_wins: got %h expected 08", d); end
        write_reg(2'd0, 8'h08);
        read_reg(BASE, d, h);
        assertions++;
        if (d !== 8'h00) begin failures++; $display("[TB] FAIL w1c_clear: got %h expected 00", d); end
        read_reg(BASE + 8'd4, d, h);
        assertions++;
        if (d !== 8'h00 || h !== 1'b0) begin failures++; $display("[TB] FAIL out_of_range: got %h hit %b expected 00 0", d, h); end
    endtask

    task automatic test_random;
        logic [7:0] d; logic h; bit seen;
        logic [7:0] m, pend, expv;
        bit rr;
        int w, guard;
        for (int iter = 0; iter < 6; iter++) begin
            do_reset;
            m    = 8'($urandom_range(0, 255));
            rr   = 1'($urandom_range(0, 1));
            pend = 8'($urandom_range(1, 255));
            write_reg(2'd1, m);
            write_reg(2'd3, {6'b000000, rr, 1'b1});
            pulse_irq(pend);
            guard = 0;
            while ((pend & m) != 8'h00 && guard < 8) begin
                wait_int(seen);
                assertions++;
                if (!seen) begin
                    failures++; $display("[TB] FAIL rand%0d_int: got 0 expected 1", iter);
                    break;
                end
                ack_irq;
                w = model_winner(pend & m, rr, model_rr);
                expv = 8'h80 | 8'(w);
                read_reg(BASE + 8'd2, d, h);
                assertions++;
                if (d !== expv) begin failures++; $display("[TB] FAIL rand%0d_vec: got %h expected %h", iter, d, expv); end
                write_reg(2'd2, 8'h00);
                pend[w] = 1'b0;
                model_rr = w;
                guard++;
            end
            repeat (4) @(negedge clk);
            read_reg(BASE, d, h);
            assertions++;
            if (d !== pend || cpu_interrupt !== 1'b0) begin
                failures++; $display("[TB] FAIL rand%0d_left: got pend %h int %b expected %h 0", iter, d, cpu_interrupt, pend);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset;
        test_registers;
        test_single;
        test_fixed_priority;
        test_round_robin;
        test_mask_drop;
        test_w1c_collision;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
